// File: rtl/decode_stage.sv
// TinyRV1 fetch-to-decode pipeline register.
// Holds one instruction + PC and its registered decode fields.
module decode_stage #(
    parameter int p_num_ops = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        squash,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [2:0]  out_op,
    output logic [1:0]  out_imm_type,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic        out_rf_wen,
    output logic        out_mem_ren,
    output logic        out_mem_wen,
    output logic        out_jump,
    output logic        out_branch,
    output logic        out_illegal
);

    localparam int OpW = $clog2(p_num_ops);

    localparam logic [OpW-1:0] OP_ADD  = OpW'(0);
    localparam logic [OpW-1:0] OP_ADDI = OpW'(1);
    localparam logic [OpW-1:0] OP_MUL  = OpW'(2);
    localparam logic [OpW-1:0] OP_LW   = OpW'(3);
    localparam logic [OpW-1:0] OP_SW   = OpW'(4);
    localparam logic [OpW-1:0] OP_JAL  = OpW'(5);
    localparam logic [OpW-1:0] OP_JR   = OpW'(6);
    localparam logic [OpW-1:0] OP_BNE  = OpW'(7);

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_J = 2'd2;
    localparam logic [1:0] IMM_B = 2'd3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0]    inst;
        logic [31:0]    pc;
        logic [OpW-1:0] op;
        logic [1:0]     imm_type;
        logic           rf_wen;
        logic           mem_ren;
        logic           mem_wen;
        logic           jump;
        logic           branch;
        logic           illegal;
    } dec_t;

    state_e state_q, state_d;
    dec_t   data_q, data_d;
    dec_t   dec;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_f;

    logic is_add, is_mul, is_addi, is_lw;
    logic is_sw, is_jal, is_jr, is_bne;
    logic accept, drain;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign rd_f   = in_inst[11:7];

    assign is_add  = (opcode == 7'b0110011) && (f3 == 3'b000)
                  && (f7 == 7'b0000000);
    assign is_mul  = (opcode == 7'b0110011) && (f3 == 3'b000)
                  && (f7 == 7'b0000001);
    assign is_addi = (opcode == 7'b0010011) && (f3 == 3'b000);
    assign is_lw   = (opcode == 7'b0000011) && (f3 == 3'b010);
    assign is_sw   = (opcode == 7'b0100011) && (f3 == 3'b010);
    assign is_jal  = (opcode == 7'b1101111);
    assign is_jr   = (opcode == 7'b1100111) && (f3 == 3'b000)
                  && (rd_f == 5'd0) && (in_inst[31:20] == 12'd0);
    assign is_bne  = (opcode == 7'b1100011) && (f3 == 3'b001);

    // Decode the incoming word; anything unmatched is flagged illegal.
    always_comb begin
        dec          = '0;
        dec.inst     = in_inst;
        dec.pc       = in_pc;
        unique case (1'b1)
            is_add: begin
                dec.op     = OP_ADD;
                dec.rf_wen = 1'b1;
            end
            is_mul: begin
                dec.op     = OP_MUL;
                dec.rf_wen = 1'b1;
            end
            is_addi: begin
                dec.op       = OP_ADDI;
                dec.imm_type = IMM_I;
                dec.rf_wen   = 1'b1;
            end
            is_lw: begin
                dec.op       = OP_LW;
                dec.imm_type = IMM_I;
                dec.rf_wen   = 1'b1;
                dec.mem_ren  = 1'b1;
            end
            is_sw: begin
                dec.op       = OP_SW;
                dec.imm_type = IMM_S;
                dec.mem_wen  = 1'b1;
            end
            is_jal: begin
                dec.op       = OP_JAL;
                dec.imm_type = IMM_J;
                dec.rf_wen   = 1'b1;
                dec.jump     = 1'b1;
            end
            is_jr: begin
                dec.op   = OP_JR;
                dec.jump = 1'b1;
            end
            is_bne: begin
                dec.op       = OP_BNE;
                dec.imm_type = IMM_B;
                dec.branch   = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        // x0 is hardwired; never request a write to it.
        if (rd_f == 5'd0) begin
            dec.rf_wen = 1'b0;
        end
    end

    assign in_rdy  = (state_q == EMPTY) || out_rdy;
    assign out_val = (state_q == FULL);
    assign accept  = in_val && in_rdy && !squash;
    assign drain   = out_val && out_rdy;

    // Next-state: squash wins, then accept (replaces), then drain.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (squash) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
            data_d  = dec;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    // Pipeline register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_inst     = data_q.inst;
    assign out_pc       = data_q.pc;
    assign out_op       = data_q.op;
    assign out_imm_type = data_q.imm_type;
    assign out_rd       = data_q.inst[11:7];
    assign out_rs1      = data_q.inst[19:15];
    assign out_rs2      = data_q.inst[24:20];
    assign out_rf_wen   = data_q.rf_wen;
    assign out_mem_ren  = data_q.mem_ren;
    assign out_mem_wen  = data_q.mem_wen;
    assign out_jump     = data_q.jump;
    assign out_branch   = data_q.branch;
    assign out_illegal  = data_q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Fetch-to-decode pipeline stage for the TinyRV1 processor. It registers one instruction and its PC from fetch behind a val/rdy handshake, and decodes opcode, funct3 and funct7 into control fields. One of these fields is `imm_type`, which drives the immediate generator in the decode/execute path. It supports squash on taken jumps/branches and flags illegal encodings.

## Interface
- `p_num_ops`, default 8, meaning number of legal TinyRV1 ops; fixed, not to be overridden.
- `clk` input 1, single clock; all state updates on rising edge.
- `rst_n` input 1, reset; synchronous, active-low.
- `in_val` input 1, fetch presents a valid instruction.
- `in_rdy` output 1, stage can accept this cycle.
- `in_inst` input 32, raw instruction word.
- `in_pc` input 32, PC of `in_inst`.
- `squash` input 1, discard held and incoming instruction.
- `out_val` output 1, decoded instruction valid.
- `out_rdy` input 1, downstream accepts.
- `out_inst` output 32, registered instruction, forwarded to the immediate generator.
- `out_pc` output 32, registered PC.
- `out_op` output 3, op code: 0 ADD, 1 ADDI, 2 MUL, 3 LW, 4 SW, 5 JAL, 6 JR, 7 BNE.
- `out_imm_type` output 2, immediate format: 0 I (ADDI, LW), 1 S (SW), 2 J (JAL), 3 B (BNE); 0 for R-type, JR and illegal.
- `out_rd`, `out_rs1`, `out_rs2` output 5 each, register fields `inst[11:7]`, `inst[19:15]`, `inst[24:20]`.
- `out_rf_wen` output 1, set for ADD, ADDI, MUL, LW, JAL, and forced 0 when rd==0.
- `out_mem_ren` output 1, set for LW. `out_mem_wen` output 1, set for SW.
- `out_jump` output 1, set for JAL and JR. `out_branch` output 1, set for BNE.
- `out_illegal` output 1, encoding not in TinyRV1.

## Operation
- One-entry pipeline register; state is `full` (0 EMPTY, 1 FULL) plus the data fields.
- `in_rdy = !full || out_rdy`; `out_val = full`. Neither output is registered separately from `full`.
- Accept occurs when `in_val && in_rdy && !squash`: load inst/pc, decode, set `full`.
- Drain occurs when `out_val && out_rdy` with no accept: clear `full`.
- Accept and drain in the same cycle: the register is replaced and `full` stays 1 (full throughput, no bubble).
- `squash` has priority over everything. Next cycle `full=0`, and the incoming instruction is dropped even if `in_val` is set. `in_rdy` is unaffected by `squash`.
- Decode is computed from `in_inst` at accept and registered. The fields are therefore stable while FULL and `out_rdy=0`.
- Legal encodings:
  - ADD: opcode 0110011, f3 000, f7 0000000.
  - MUL: opcode 0110011, f3 000, f7 0000001.
  - ADDI: opcode 0010011, f3 000.
  - LW: opcode 0000011, f3 010.
  - SW: opcode 0100011, f3 010.
  - JAL: opcode 1101111.
  - JR: opcode 1100111, f3 000, rd 0, imm 0.
  - BNE: opcode 1100011, f3 001.
- Illegal encodings: `out_illegal=1`, `out_op=0`, and all enables/jump/branch are 0. The instruction still occupies the stage and handshakes normally.

## Timing
- Latency 1 cycle from accept to `out_val`. Throughput 1 instruction/cycle.
- Reset (`rst_n=0` at an edge): `full=0` and all data fields 0, so `out_val=0`, decode outputs 0 and `in_rdy=1`. Reset overrides accept and squash. Reset mid-stall discards the held instruction.
- While FULL and `out_rdy=0`: `in_rdy=0` and all outputs hold exactly.
- `rd==0` on a writing op: `out_rf_wen=0`; the other fields decode normally.
- PC is carried through unchanged; there is no arithmetic in this stage.

## Test plan
- Reset then single ADDI: `0x00500093` at pc `0x200` -> next cycle `out_val=1`, op 1, imm_type 0, rd 1, rs1 0, rf_wen 1, pc `0x200`.
- Back-to-back stream with `out_rdy=1`: ADD `0x002081B3`, MUL `0x022081B3`, LW `0x0000A103`, SW `0x0020A223` -> ops 0, 2, 3, 4 on consecutive cycles, no bubbles, SW imm_type 1 with mem_wen 1.
- Stall: BNE `0x00209463` held with `out_rdy=0` for 3 cycles -> `in_rdy=0`, op 7, imm_type 3, branch 1 held stable; release with `in_val` high gives same-cycle replace.
- Squash: FULL with JR `0x00008067` (op 6, jump 1); assert `squash` together with `in_val` -> next cycle `out_val=0` and the incoming instruction is never presented.
- Illegal `0x0000700B` and ADD with f7 `0100000` (`0x402081B3`) -> `illegal=1`, op 0, all enables 0, handshake completes.
- `rst_n` low while FULL and stalled -> next cycle all outputs 0, `in_rdy=1`.
